// File: rtl/ahbdma_pkg.sv
// ahbdma_pkg
// Shared types and AHB-Lite encodings for the AHB DMA manager.
//   state_t        - copy engine states
//   HTRANS_*       - transfer-type encodings used by the manager
//   HBURST_SINGLE  - the only burst type issued
//   HPROT_DATA     - protection attributes for every transfer
//   size_for_xlen  - HSIZE encoding for a given data width

package ahbdma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    function automatic logic [2:0] size_for_xlen(input int xlen);
        return (xlen == 32) ? 3'd2 : 3'd3;
    endfunction

endpackage

// File: rtl/ahbdma_addrgen.sv
// ahbdma_addrgen
// Source/destination address and remaining-word counters for the copy engine.
// Loaded when a copy is launched; stepped once per completed word.
// Ports:
//   HCLK, HRESETn        clock, async active-low reset
//   load                 capture src_load/dst_load/len_load
//   step                 advance both addresses by one word, decrement count
//   src_load, dst_load   word-aligned start addresses
//   len_load             number of words to copy
//   src_next             address of the next source word (current src + STRIDE)
//   dst                  current destination address
//   count                words still to copy
//   count_zero           count == 0

module ahbdma_addrgen
    import ahbdma_pkg::*;
#(
    parameter int PA_BITS = 34,
    parameter int LEN_W   = 16,
    parameter int STRIDE  = 8
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               load,
    input  logic               step,
    input  logic [PA_BITS-1:0] src_load,
    input  logic [PA_BITS-1:0] dst_load,
    input  logic [LEN_W-1:0]   len_load,
    output logic [PA_BITS-1:0] src_next,
    output logic [PA_BITS-1:0] dst,
    output logic [LEN_W-1:0]   count,
    output logic               count_zero
);

    localparam logic [PA_BITS-1:0] STRIDE_A = PA_BITS'(STRIDE);

    logic [PA_BITS-1:0] src;

    // Address sums are PA_BITS wide, so running off the top wraps to 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src   <= '0;
            dst   <= '0;
            count <= '0;
        end else if (load) begin
            src   <= src_load;
            dst   <= dst_load;
            count <= len_load;
        end else if (step) begin
            src   <= src_next;
            dst   <= dst + STRIDE_A;
            count <= count - LEN_W'(1);
        end
    end

    assign src_next   = src + STRIDE_A;
    assign count_zero = (count == '0);

endmodule

// File: rtl/ahb_dma_manager.sv
// ahb_dma_manager
// AHB-Lite manager that copies Len XLEN-wide words from SrcAddr to DstAddr,
// one single read followed by one single write per word, never more than one
// transfer outstanding.
// Optional feature macro: AHBDMA_ABORT_EN adds the Abort input; an abort lets
// the word in flight finish, then ends the copy with a normal Done.
// Ports:
//   HCLK, HRESETn              bus clock, async active-low reset
//   Start, SrcAddr, DstAddr,   launch a copy (ignored while Busy)
//   Len
//   Abort                      (AHBDMA_ABORT_EN only) stop after current word
//   Busy, Done, Err, ErrAddr   status; ErrAddr holds the faulting address
//   HADDR..HMASTLOCK           AHB-Lite manager outputs
//   HRDATA, HREADY, HRESP      AHB-Lite manager inputs
//
// state  | meaning
// IDLE   | waiting for Start
// RADDR  | read address phase (NONSEQ, HWRITE=0, HADDR=src)
// RDATA  | read data phase, data captured on an OKAY response
// WADDR  | write address phase (NONSEQ, HWRITE=1, HADDR=dst)
// WDATA  | write data phase, counters step on an OKAY response
// FIN    | Done pulse, back to IDLE

module ahb_dma_manager
    import ahbdma_pkg::*;
#(
    parameter int PA_BITS = 34,
    parameter int XLEN    = 64,
    parameter int LEN_W   = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                Start,
    input  logic [PA_BITS-1:0]  SrcAddr,
    input  logic [PA_BITS-1:0]  DstAddr,
    input  logic [LEN_W-1:0]    Len,
`ifdef AHBDMA_ABORT_EN
    input  logic                Abort,
`endif
    output logic                Busy,
    output logic                Done,
    output logic                Err,
    output logic [PA_BITS-1:0]  ErrAddr,
    output logic [PA_BITS-1:0]  HADDR,
    output logic [XLEN-1:0]     HWDATA,
    output logic [XLEN/8-1:0]   HWSTRB,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [1:0]          HTRANS,
    output logic                HMASTLOCK,
    input  logic [XLEN-1:0]     HRDATA,
    input  logic                HREADY,
    input  logic                HRESP
);

    localparam int                 BYTES      = XLEN / 8;
    localparam logic [PA_BITS-1:0] ALIGN_MASK = ~(PA_BITS'(BYTES - 1));

    state_t             state;
    logic [XLEN-1:0]    data_q;
    logic               accept_start;
    logic               step;
    logic               last_word;
    logic               stop_early;
    logic               finish_copy;
    logic [PA_BITS-1:0] src_next;
    logic [PA_BITS-1:0] dst;
    logic [LEN_W-1:0]   count;
    logic               count_zero;

    assign HSIZE     = size_for_xlen(XLEN);
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // FIN is not busy, so a Start coinciding with the Done pulse is honoured.
    assign accept_start = Start && ((state == ST_IDLE) || (state == ST_FIN));
    assign step         = (state == ST_WDATA) && HREADY && !HRESP;
    // count_zero can only be seen here if Len wrapped; treat it as last too.
    assign last_word    = (count == LEN_W'(1)) || count_zero;
    assign finish_copy  = last_word || stop_early;

`ifdef AHBDMA_ABORT_EN
    logic abort_pend;

    // An abort is remembered until the word in flight completes its write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            abort_pend <= 1'b0;
        end else if (accept_start) begin
            abort_pend <= 1'b0;
        end else if (Busy && Abort) begin
            abort_pend <= 1'b1;
        end
    end

    assign stop_early = abort_pend || Abort;
`else
    assign stop_early = 1'b0;
`endif

    ahbdma_addrgen #(
        .PA_BITS (PA_BITS),
        .LEN_W   (LEN_W),
        .STRIDE  (BYTES)
    ) u_addrgen (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load       (accept_start),
        .step       (step),
        .src_load   (SrcAddr & ALIGN_MASK),
        .dst_load   (DstAddr & ALIGN_MASK),
        .len_load   (Len),
        .src_next   (src_next),
        .dst        (dst),
        .count      (count),
        .count_zero (count_zero)
    );

    // Bus outputs are set on entry to the state that presents them, so HADDR
    // and HWRITE only move when an address phase begins and stay put through
    // every stalled cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            HTRANS  <= HTRANS_IDLE;
            HADDR   <= '0;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            HWSTRB  <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            ErrAddr <= '0;
            data_q  <= '0;
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            if (accept_start) begin
                ErrAddr <= '0;
                if (Len != '0) begin
                    state  <= ST_RADDR;
                    HTRANS <= HTRANS_NONSEQ;
                    HWRITE <= 1'b0;
                    HADDR  <= SrcAddr & ALIGN_MASK;
                    Busy   <= 1'b1;
                end else begin
                    state <= ST_FIN;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_RADDR: begin
                        if (HREADY) begin
                            state  <= ST_RDATA;
                            HTRANS <= HTRANS_IDLE;
                        end
                    end
                    ST_RDATA: begin
                        if (HRESP) begin
                            // HADDR still holds the faulting read address.
                            ErrAddr <= HADDR;
                            if (HREADY) begin
                                state <= ST_IDLE;
                                Err   <= 1'b1;
                                Busy  <= 1'b0;
                            end
                        end else if (HREADY) begin
                            data_q <= HRDATA;
                            state  <= ST_WADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b1;
                            HADDR  <= dst;
                        end
                    end
                    ST_WADDR: begin
                        if (HREADY) begin
                            state  <= ST_WDATA;
                            HTRANS <= HTRANS_IDLE;
                            HWDATA <= data_q;
                            HWSTRB <= '1;
                        end
                    end
                    ST_WDATA: begin
                        if (HRESP) begin
                            ErrAddr <= HADDR;
                            if (HREADY) begin
                                state  <= ST_IDLE;
                                HWSTRB <= '0;
                                Err    <= 1'b1;
                                Busy   <= 1'b0;
                            end
                        end else if (HREADY) begin
                            HWSTRB <= '0;
                            if (finish_copy) begin
                                state <= ST_FIN;
                                Done  <= 1'b1;
                                Busy  <= 1'b0;
                            end else begin
                                state  <= ST_RADDR;
                                HTRANS <= HTRANS_NONSEQ;
                                HWRITE <= 1'b0;
                                HADDR  <= src_next;
                            end
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        HTRANS <= HTRANS_IDLE;
                        Busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ahb_dma_manager.md
Name: ahb_dma_manager

Overview:
- AHB-Lite manager (initiator) that copies a block of XLEN-wide words from a source address to a destination address.
- Each word is moved as a single read transfer followed by a single write transfer.
- Intended as a second bus manager into the uncore fabric, for memory-to-peripheral and memory-to-memory copies without the core.
- Non-pipelined: at most one outstanding AHB transfer at a time.

Parameters:
- PA_BITS, 34, physical address width.
- XLEN, 64, data width in bits (32 or 64).
- LEN_W, 16, width of the word-count field.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse that launches a copy; ignored while Busy.
- SrcAddr  in  PA_BITS  source byte address, sampled on Start; low log2(XLEN/8) bits forced to 0.
- DstAddr  in  PA_BITS  destination byte address, sampled on Start; low bits forced to 0.
- Len  in  LEN_W  number of words to copy, sampled on Start.
- Busy  out  1  high from the cycle after Start until the Done/Err pulse.
- Done  out  1  one-cycle pulse on successful completion.
- Err  out  1  one-cycle pulse when the copy terminates on HRESP error.
- ErrAddr  out  PA_BITS  address of the faulting transfer; held until the next Start.
- HADDR  out  PA_BITS  AHB address.
- HWDATA  out  XLEN  AHB write data.
- HWSTRB  out  XLEN/8  write strobes; all ones during a write data phase, otherwise 0.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  log2(XLEN/8) during transfers.
- HBURST  out  3  constant SINGLE (3'b000).
- HPROT  out  4  constant 4'b0011.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10).
- HMASTLOCK  out  1  constant 0.
- HRDATA  in  XLEN  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error response.

Behaviour:
- Reset (async, HRESETn=0):
  - State IDLE.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, HWSTRB=0.
  - Busy=0, Done=0, Err=0, ErrAddr=0.
  - Asserting reset mid-copy abandons the copy immediately; no Done or Err pulse.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, FIN.
- IDLE:
  - Start with Len!=0 → RADDR; latch the source and destination addresses, set count=Len, Busy=1.
  - Start with Len=0 → FIN (no bus traffic).
- RADDR:
  - Drive HTRANS=NONSEQ, HWRITE=0, HADDR=src.
  - Advance to RDATA only on a cycle with HREADY=1 (address phase accepted); otherwise hold all outputs stable.
- RDATA:
  - Drive HTRANS=IDLE.
  - On HREADY=1 && HRESP=0: capture HRDATA into the data register → WADDR.
- WADDR:
  - Drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst.
  - Advance to WDATA on HREADY=1.
- WDATA:
  - Drive HTRANS=IDLE, HWDATA=data register, HWSTRB all ones.
  - On HREADY=1 && HRESP=0: src+=XLEN/8, dst+=XLEN/8, count-=1.
  - Then → FIN if count reaches 0, else → RADDR.
- FIN: Done=1 for one cycle, Busy=0 → IDLE.
- Error handling:
  - HRESP=1 in RDATA or WDATA (first error cycle, HREADY=0): latch ErrAddr; issue no further transfer.
  - When HREADY=1: Err=1 for one cycle, Busy=0 → IDLE.
- Read data: the data register never updates on an errored read.
- Address arithmetic: modulo 2^PA_BITS; wrap from all-ones to 0 is silent.
- Latency: minimum 4 cycles per word with zero-wait subordinates; Done follows the last write data phase by 1 cycle.
- Outputs are registered; HADDR/HWRITE change only when entering an address-phase state.

Optional Feature:
- Macro AHBDMA_ABORT_EN.
- When defined, adds input port Abort (1 bit).
  - Abort seen in RADDR or WADDR while HREADY=0: the transfer may be withdrawn only after it is accepted, so the block completes the pending transfer, then → FIN.
  - Abort seen in RDATA or WDATA: finish that data phase, skip the remaining words, → FIN.
  - Done pulses normally; count register shows the remaining words.
- When undefined: no Abort port; every copy runs to completion or error.

Decomposition:
- Shared package ahbdma_pkg:
  - State enum.
  - HTRANS_IDLE / HTRANS_NONSEQ constants.
  - HBURST_SINGLE, HPROT_DATA constants.
- One natural sub-module: ahbdma_addrgen, holding the src/dst/count registers with load-on-Start and increment/decrement-on-enable, plus a count==0 flag.

Test Plan:
- Zero-wait copy: SrcAddr=0x8000_0000, DstAddr=0x8000_1000, Len=3.
  - Expect 6 transfers in order R/W/R/W/R/W at +8 strides (XLEN=64).
  - Destination words equal source; Done 12 cycles after Start+1.
- Wait states: subordinate holds HREADY=0 for 2 cycles on every data phase.
  - HADDR, HWDATA and HWRITE stable while stalled.
  - Total 24 cycles for Len=3.
- Error on read: second read returns a two-cycle HRESP error.
  - Err pulses once; ErrAddr=Src+8; no write of word 1; Busy drops.
- Len=0 and Start while busy:
  - Len=0: Done pulses on the 2nd cycle with HTRANS IDLE throughout.
  - Start during a copy: ignored, latched addresses unchanged.
- Reset mid-copy: deassert HRESETn in WDATA.
  - All outputs immediately at reset values; no Done or Err afterwards.
- Wrap and abort (with AHBDMA_ABORT_EN):
  - Src=2^PA_BITS-8, Len=2: second read at address 0.
  - Abort in RDATA of word 1 of 4: completes that word, Done, 3 words remain.
